// File: rtl/jt12_mix_pkg.sv
// ---------------------------------------------------------------------------
// jt12_mix_pkg
// Shared definitions for the JT12 N-source audio mixer.
//   state_t     : mixer sequencer states (IDLE, ACC, OUT)
//   GAIN_UNITY  : gain code for a gain of 1.0 (4 fractional bits)
//   FRAC_BITS   : number of fractional bits in a gain code
//   sat()       : clamp a wide signed value to a signed ow-bit range
// ---------------------------------------------------------------------------
package jt12_mix_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam logic [7:0] GAIN_UNITY = 8'h10;
   localparam int         FRAC_BITS  = 4;

   // Clamp to [-2^(ow-1), 2^(ow-1)-1]. Works on a fixed 64-bit container so
   // it can serve any parameterisation; the caller keeps the low ow bits.
   function automatic logic signed [63:0] sat(input logic signed [63:0] acc,
                                              input int                 ow);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 1));
      if (acc > hi) begin
         return hi;
      end else if (acc < lo) begin
         return lo;
      end else begin
         return acc;
      end
   endfunction

endpackage

// File: rtl/jt12_mixer_mac.sv
// ---------------------------------------------------------------------------
// jt12_mix_mac
// Registered multiply-accumulate used by jt12_mixer.
//   clk, rst : clock, synchronous active-high reset (clears the accumulator)
//   cen      : clock enable; the accumulator only changes when cen=1
//   clr      : load zero (takes priority over en)
//   en       : add (sample * gain) >>> FRAC_BITS to the accumulator
//   sample   : signed W-bit sample
//   gain     : unsigned GW-bit gain, zero-extended before the multiply
//   acc      : signed AW-bit running sum
// ---------------------------------------------------------------------------
module jt12_mix_mac
   import jt12_mix_pkg::*;
#(
   parameter int W  = 16,
   parameter int GW = 8,
   parameter int AW = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cen,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [W-1:0]  sample,
   input  logic        [GW-1:0] gain,
   output logic signed [AW-1:0] acc
);

   // Product width of a W-bit signed value times a (GW+1)-bit signed value.
   localparam int PW = W + GW + 1;
   // Sum width, always wider than both the product and the accumulator so
   // the addition never needs to care which of the two is larger.
   localparam int SW = AW + PW;

   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [GW:0]   gain_s;
   logic signed [PW-1:0] prod;
   logic signed [SW-1:0] sum;
   logic                 unused_sum_hi;

   // Gains are unsigned: a leading zero keeps 8'hFF from reading as -1.
   assign gain_s = $signed({1'b0, gain});
   assign prod   = PW'(sample) * PW'(gain_s);
   assign sum    = SW'(acc_q) + (SW'(prod) >>> FRAC_BITS);

   // The accumulator is sized so the full frame sum always fits; the extra
   // sum bits are pure sign extension.
   assign unused_sum_hi = ^sum[SW-1:AW];

   always_comb begin
      acc_d = acc_q;
      if (cen) begin
         if (clr) begin
            acc_d = '0;
         end else if (en) begin
            acc_d = sum[AW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/jt12_mixer.sv
// ---------------------------------------------------------------------------
// jt12_mixer
// N-source saturating audio mixer with per-source programmable gain. A frame
// is snapshotted on src_sample, accumulated one source per cen cycle through
// a single MAC, then saturated to OW bits and presented on snd.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   cen          : clock enable, all state advances only when cen=1
//   src_data     : packed signed samples, source i at [i*W +: W]
//   src_sample   : new-frame strobe (ignored while a frame is in flight)
//   gain_we      : shadow gain write strobe
//   gain_addr    : shadow gain index (indexes >= N_SRC are ignored)
//   gain_din     : gain value, GW-4 integer bits, 4 fractional bits
//   snd          : saturated mix, held between frames
//   snd_sample   : one cen-cycle pulse marking a new snd value
//   busy         : high from frame acceptance until the result is output
//   clip         : (JT12_MIXER_CLIP_EN only) sticky saturation flag, cleared
//                  by rst or by a gain write to address all-ones
//
// Build option: define JT12_MIXER_CLIP_EN to add the clip output.
//
// Timing: accept at cen cycle 0, ACC for N_SRC cen cycles, OUT on cycle
// N_SRC+1 which registers snd/snd_sample. A new src_sample is accepted on
// the next cen cycle, giving a minimum frame period of N_SRC+2.
// ---------------------------------------------------------------------------
module jt12_mixer
   import jt12_mix_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int W     = 16,
   parameter int GW    = 8,
   parameter int OW    = 16,
   localparam int GAW  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cen,
   input  logic [N_SRC*W-1:0]     src_data,
   input  logic                   src_sample,
   input  logic                   gain_we,
   input  logic [GAW-1:0]         gain_addr,
   input  logic [GW-1:0]          gain_din,
   output logic signed [OW-1:0]   snd,
   output logic                   snd_sample,
   output logic                   busy
`ifdef JT12_MIXER_CLIP_EN
   ,
   output logic                   clip
`endif
);

   localparam int AW = W + GW - FRAC_BITS + $clog2(N_SRC) + 1;

   state_t                state_q, state_d;
   logic [GAW-1:0]        idx_q, idx_d;
   logic signed [W-1:0]   samp_q [N_SRC];
   logic signed [W-1:0]   samp_d [N_SRC];
   logic [GW-1:0]         gain_q [N_SRC];
   logic [GW-1:0]         gain_d [N_SRC];
   logic [GW-1:0]         shad_q [N_SRC];
   logic [GW-1:0]         shad_d [N_SRC];
   logic signed [OW-1:0]  snd_q, snd_d;
   logic                  snd_sample_q, snd_sample_d;
   logic                  busy_q, busy_d;

   logic                  gain_wr;
   logic                  mac_clr;
   logic                  mac_en;
   logic signed [AW-1:0]  acc;
   logic signed [63:0]    acc_ext;
   logic signed [63:0]    sat_full;
   logic                  unused_sat_hi;

`ifdef JT12_MIXER_CLIP_EN
   logic                  clip_q, clip_d;
   logic                  clip_clr;
`endif

   // ------------------------------------------------------------------------
   // Saturation of the finished accumulator
   // ------------------------------------------------------------------------
   assign acc_ext       = {{(64 - AW){acc[AW-1]}}, acc};
   assign sat_full      = sat(acc_ext, OW);
   assign unused_sat_hi = ^sat_full[63:OW];

   // ------------------------------------------------------------------------
   // Gain write decode. With the clip option the all-ones address is a clear
   // command and never lands in the gain file.
   // ------------------------------------------------------------------------
`ifdef JT12_MIXER_CLIP_EN
   assign clip_clr = cen && gain_we && (&gain_addr);
   assign gain_wr  = cen && gain_we && (32'(gain_addr) < N_SRC) && !(&gain_addr);
`else
   assign gain_wr  = cen && gain_we && (32'(gain_addr) < N_SRC);
`endif

   // ------------------------------------------------------------------------
   // Sequencer, snapshot array and gain file
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      samp_d       = samp_q;
      gain_d       = gain_q;
      shad_d       = shad_q;
      snd_d        = snd_q;
      snd_sample_d = snd_sample_q;
      busy_d       = busy_q;
      mac_clr      = 1'b0;
      mac_en       = 1'b0;

      if (gain_wr) begin
         shad_d[gain_addr] = gain_din;
      end

      if (cen) begin
         snd_sample_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (src_sample) begin
                  for (int i = 0; i < N_SRC; i++) begin
                     samp_d[i] = src_data[i*W +: W];
                  end
                  // shad_d already carries a write from this same cycle.
                  gain_d  = shad_d;
                  idx_d   = '0;
                  mac_clr = 1'b1;
                  busy_d  = 1'b1;
                  state_d = ACC;
               end
            end
            ACC: begin
               mac_en = 1'b1;
               if (idx_q == GAW'(N_SRC - 1)) begin
                  idx_d   = '0;
                  state_d = OUT;
               end else begin
                  idx_d = GAW'(idx_q + 1'b1);
               end
            end
            OUT: begin
               snd_d        = sat_full[OW-1:0];
               snd_sample_d = 1'b1;
               busy_d       = 1'b0;
               state_d      = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

`ifdef JT12_MIXER_CLIP_EN
   // Set wins over clear when both happen on the same cen cycle.
   always_comb begin
      clip_d = clip_q;
      if (clip_clr) begin
         clip_d = 1'b0;
      end
      if (cen && (state_q == OUT) && (sat_full != acc_ext)) begin
         clip_d = 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         snd_q        <= '0;
         snd_sample_q <= 1'b0;
         busy_q       <= 1'b0;
         for (int i = 0; i < N_SRC; i++) begin
            samp_q[i] <= '0;
            gain_q[i] <= GW'(GAIN_UNITY);
            shad_q[i] <= GW'(GAIN_UNITY);
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         snd_q        <= snd_d;
         snd_sample_q <= snd_sample_d;
         busy_q       <= busy_d;
         samp_q       <= samp_d;
         gain_q       <= gain_d;
         shad_q       <= shad_d;
      end
   end

`ifdef JT12_MIXER_CLIP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         clip_q <= 1'b0;
      end else begin
         clip_q <= clip_d;
      end
   end

   assign clip = clip_q;
`endif

   // ------------------------------------------------------------------------
   // Multiply-accumulate
   // ------------------------------------------------------------------------
   jt12_mix_mac #(
      .W  (W),
      .GW (GW),
      .AW (AW)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .cen    (cen),
      .clr    (mac_clr),
      .en     (mac_en),
      .sample (samp_q[idx_q]),
      .gain   (gain_q[idx_q]),
      .acc    (acc)
   );

   assign snd        = snd_q;
   assign snd_sample = snd_sample_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_jt12_mixer.sv
// ---------------------------------------------------------------------------
// tb_jt12_mixer
// Directed bench for jt12_mixer (N_SRC=4, W=16, GW=8, OW=16). Expected values
// are hand-computed: term = (sample * gain) >>> 4, summed and clamped.
// ---------------------------------------------------------------------------
module tb_jt12_mixer;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int GW = 8;
   localparam int OW = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cen;
   logic [N*W-1:0]        src_data;
   logic                  src_sample;
   logic                  gain_we;
   logic [1:0]            gain_addr;
   logic [GW-1:0]         gain_din;
   logic signed [OW-1:0]  snd;
   logic                  snd_sample;
   logic                  busy;
`ifdef JT12_MIXER_CLIP_EN
   logic                  clip;
`endif

   int total   = 0;
   int bad     = 0;
   int cen_div = 1;

   jt12_mixer #(
      .N_SRC (N),
      .W     (W),
      .GW    (GW),
      .OW    (OW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cen        (cen),
      .src_data   (src_data),
      .src_sample (src_sample),
      .gain_we    (gain_we),
      .gain_addr  (gain_addr),
      .gain_din   (gain_din),
      .snd        (snd),
      .snd_sample (snd_sample),
      .busy       (busy)
`ifdef JT12_MIXER_CLIP_EN
      ,
      .clip       (clip)
`endif
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cen cycle: cen_div-1 idle clk edges, then one enabled edge.
   task automatic tick();
      for (int i = 0; i < cen_div - 1; i++) begin
         cen = 1'b0;
         step();
      end
      cen = 1'b1;
      step();
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_src(input int a, input int b, input int c, input int d);
      src_data = {16'(d), 16'(c), 16'(b), 16'(a)};
   endtask

   task automatic write_gain(input int addr, input int val);
      gain_we   = 1'b1;
      gain_addr = 2'(addr);
      gain_din  = 8'(val);
      tick();
      gain_we   = 1'b0;
   endtask

   // Wait (bounded) for snd_sample; lat counts cen cycles already elapsed.
   task automatic wait_out(inout int lat, output int res);
      while (snd_sample !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      res = int'(snd);
   endtask

   task automatic run_frame(input int a, input int b, input int c, input int d,
                            output int res, output int lat);
      set_src(a, b, c, d);
      src_sample = 1'b1;
      tick();
      src_sample = 1'b0;
      lat = 0;
      wait_out(lat, res);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int res;
      int lat;
      int pulses;

      rst        = 1'b1;
      cen        = 1'b1;
      src_sample = 1'b0;
      gain_we    = 1'b0;
      gain_addr  = '0;
      gain_din   = '0;
      src_data   = '0;
      step();
      step();
      check("rst_snd", int'(snd), 0);
      check("rst_snd_sample", int'(snd_sample), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      step();

      // Unity gains: 100 - 50 + 200 + 0
      run_frame(100, -50, 200, 0, res, lat);
      check("unity_snd", res, 250);
      check("unity_lat", lat, 5);
      tick();
      check("unity_pulse_len", int'(snd_sample), 0);
      check("unity_busy_after", int'(busy), 0);

      // gain[2] = 0.5: 100 - 50 + 100 + 0
      write_gain(2, 8'h08);
      run_frame(100, -50, 200, 0, res, lat);
      check("half_gain_snd", res, 150);
      check("half_gain_lat", lat, 5);
      tick();

      // gain[1] = 0 written during ACC must not touch the running frame
      set_src(100, -50, 200, 0);
      src_sample = 1'b1;
      tick();
      src_sample = 1'b0;
      check("acc_busy", int'(busy), 1);
      write_gain(1, 8'h00);
      lat = 1;
      wait_out(lat, res);
      check("acc_write_snd", res, 150);
      check("acc_write_lat", lat, 5);
      tick();
      run_frame(100, -50, 200, 0, res, lat);
      check("next_frame_snd", res, 200);
      tick();

      // Saturation, both directions
      for (int i = 0; i < N; i++) write_gain(i, 8'hFF);
      run_frame(32767, 32767, 32767, 32767, res, lat);
      check("sat_pos_snd", res, 32767);
      tick();
      run_frame(-32768, -32768, -32768, -32768, res, lat);
      check("sat_neg_snd", res, -32768);
      tick();
`ifdef JT12_MIXER_CLIP_EN
      check("clip_set", int'(clip), 1);
      tick();
      tick();
      check("clip_sticky", int'(clip), 1);
      write_gain(3, 8'h00);
      check("clip_cleared", int'(clip), 0);
`endif

      // Back to unity gains through reset, then the dropped-strobe case
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_src(10, 20, 30, 40);
      src_sample = 1'b1;
      tick();
      src_sample = 1'b0;
      check("drop_busy", int'(busy), 1);
      tick();
      set_src(1, 1, 1, 1);
      src_sample = 1'b1;
      tick();
      src_sample = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (snd_sample === 1'b1) pulses++;
      end
      check("drop_pulses", pulses, 1);
      check("drop_snd", int'(snd), 100);
      check("drop_busy_end", int'(busy), 0);

      // cen at 1/3 duty through a frame
      cen_div = 3;
      run_frame(100, -50, 200, 0, res, lat);
      check("slow_cen_snd", res, 250);
      check("slow_cen_lat", lat, 5);
      cen = 1'b0;
      step();
      check("slow_cen_pulse_hold", int'(snd_sample), 1);
      tick();
      check("slow_cen_pulse_end", int'(snd_sample), 0);
      cen_div = 1;

      // Reset in the middle of ACC with non-unity gains loaded
      for (int i = 0; i < N; i++) write_gain(i, 8'hFF);
      set_src(100, -50, 200, 0);
      src_sample = 1'b1;
      tick();
      src_sample = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      step();
      check("midrst_busy", int'(busy), 0);
      check("midrst_snd", int'(snd), 0);
      check("midrst_snd_sample", int'(snd_sample), 0);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (snd_sample === 1'b1) pulses++;
      end
      check("midrst_no_pulse", pulses, 0);
      run_frame(100, -50, 200, 0, res, lat);
      check("midrst_unity_snd", res, 250);
      check("midrst_unity_lat", lat, 5);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
